data_mem_unit: RTL and testbench

- Data-memory responder on the far end of the control FSM's load/store sequences: the control FSM issues one request and waits for `done`.
- Owns a word-organised RAM and executes LW/LH/LB/SW/SH/SB with fixed, documented latency.
- Sub-word stores use an internal read-modify-write sequence.
- Sign-extends sub-word loads and flags misaligned or illegal accesses.

---
 rtl/data_mem_if.sv | 34 +++
 rtl/data_mem_unit.sv | 184 ++++++++++++++++++
 tb/tb_data_mem_unit.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_if.sv
// ---------------------------------------------------------------------------
// data_mem_if
//   Request/response bundle between the control FSM (master) and the data
//   memory unit (slave). One request is issued and the master waits for done.
//
//   req    master->slave  request strobe, only honoured while ready=1
//   op     master->slave  000 LW, 001 LH, 010 LB, 100 SW, 101 SH, 110 SB
//   addr   master->slave  byte address
//   wdata  master->slave  store data (SH low half, SB low byte)
//   ready  slave->master  unit idle and able to accept
//   done   slave->master  one-cycle completion pulse
//   err    slave->master  one-cycle reject pulse, always together with done
//   rdata  slave->master  last successful load result, sign-extended
// ---------------------------------------------------------------------------
interface data_mem_if;
  logic        req;
  logic [2:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        done;
  logic        err;
  logic [31:0] rdata;

  modport master (
    output req, op, addr, wdata,
    input  ready, done, err, rdata
  );

  modport slave (
    input  req, op, addr, wdata,
    output ready, done, err, rdata
  );
endinterface

// File: rtl/data_mem_unit.sv
// ---------------------------------------------------------------------------
// data_mem_unit
//   Word-organised data RAM that executes LW/LH/LB/SW/SH/SB one request at a
//   time with fixed latency. Sub-word stores are done as read-modify-write,
//   sub-word loads are sign-extended, misaligned/illegal requests are
//   rejected with done+err and leave RAM and rdata untouched.
//
//   Latency (accept at T): loads, SH, SB -> done at T+2; SW, rejects -> T+1.
//
//   Ports
//     clk    single clock, all state on the rising edge
//     reset  synchronous, active-high; aborts the operation in flight and
//            suppresses a write scheduled in the same cycle; RAM is kept
//     bus    data_mem_if.slave (req/op/addr/wdata in, ready/done/err/rdata out)
//
//   Parameters
//     ADDR_W     log2 of the RAM depth in 32-bit words
//     INIT_ZERO  1 = RAM contents start at zero (never cleared by reset)
// ---------------------------------------------------------------------------
module data_mem_unit #(
  parameter int ADDR_W    = 8,
  parameter bit INIT_ZERO = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  data_mem_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_RD,
    S_LOAD_DONE,
    S_STORE_WR,
    S_RMW_RD,
    S_RMW_WR,
    S_ERR
  } state_e;

  // Access size encoding taken from op[1:0]: 00 word, 01 half, 10 byte.
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  // RAM is never reset; only its power-up contents are selectable.
  logic [31:0] ram_q [DEPTH] = '{default: (INIT_ZERO ? 32'h0000_0000 : 32'hxxxx_xxxx)};

  state_e              state_q;
  logic [1:0]          size_q;
  logic [ADDR_W-1:0]   idx_q;
  logic [1:0]          off_q;
  logic [31:0]         wdata_q;
  logic [31:0]         rd_word_q;
  logic [31:0]         rdata_q;
  logic                done_q;
  logic                err_q;

  state_e              accept_state_d;
  logic                ram_we;
  logic [31:0]         ram_wdata;

  // Address bits above the RAM index are ignored so addresses wrap.
  logic                addr_hi_unused;
  assign addr_hi_unused = ^bus.addr[31:ADDR_W+2];

  // -------------------------------------------------------------------------
  // Helpers: little-endian field extraction and insertion.
  // -------------------------------------------------------------------------
  function automatic logic [31:0] load_extract(input logic [1:0]  size,
                                               input logic [1:0]  off,
                                               input logic [31:0] word);
    logic [15:0] half;
    logic [7:0]  byte_v;
    half   = off[1] ? word[31:16] : word[15:0];
    byte_v = word[{off, 3'b000} +: 8];
    case (size)
      SZ_HALF: return {{16{half[15]}}, half};
      SZ_BYTE: return {{24{byte_v[7]}}, byte_v};
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [1:0]  size,
                                              input logic [1:0]  off,
                                              input logic [31:0] word,
                                              input logic [31:0] wd);
    logic [31:0] merged;
    merged = word;
    if (size == SZ_HALF) begin
      if (off[1]) merged[31:16] = wd[15:0];
      else        merged[15:0]  = wd[15:0];
    end else begin
      merged[{off, 3'b000} +: 8] = wd[7:0];
    end
    return merged;
  endfunction

  // -------------------------------------------------------------------------
  // Request decode: destination state for the request on the bus right now.
  // -------------------------------------------------------------------------
  always_comb begin
    logic bad;
    bad            = 1'b0;
    accept_state_d = S_IDLE;
    case (bus.op)
      3'b000: begin bad = |bus.addr[1:0]; accept_state_d = S_LOAD_RD;  end
      3'b001: begin bad = bus.addr[0];    accept_state_d = S_LOAD_RD;  end
      3'b010: begin                       accept_state_d = S_LOAD_RD;  end
      3'b100: begin bad = |bus.addr[1:0]; accept_state_d = S_STORE_WR; end
      3'b101: begin bad = bus.addr[0];    accept_state_d = S_RMW_RD;   end
      3'b110: begin                       accept_state_d = S_RMW_RD;   end
      default: bad = 1'b1;
    endcase
    if (bad) accept_state_d = S_ERR;
  end

  // -------------------------------------------------------------------------
  // Control FSM with registered done/err/rdata.
  // done/err are raised on the edge entering the completing state so they
  // line up with that state and drop on the way back to IDLE.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.req) begin
            size_q  <= bus.op[1:0];
            idx_q   <= bus.addr[ADDR_W+1:2];
            off_q   <= bus.addr[1:0];
            wdata_q <= bus.wdata;
            state_q <= accept_state_d;
            if (accept_state_d == S_STORE_WR || accept_state_d == S_ERR) begin
              done_q <= 1'b1;
            end
            err_q <= (accept_state_d == S_ERR);
          end
        end
        S_LOAD_RD: begin
          // rd_word_q was captured on the accept edge.
          rdata_q <= load_extract(size_q, off_q, rd_word_q);
          done_q  <= 1'b1;
          state_q <= S_LOAD_DONE;
        end
        S_RMW_RD: begin
          done_q  <= 1'b1;
          state_q <= S_RMW_WR;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // RAM: one registered read port and one write port. The read is enabled in
  // IDLE using the live bus address, so the word is ready in the cycle after
  // acceptance. Writes only happen outside IDLE, so they never collide with
  // a read of the same word.
  // -------------------------------------------------------------------------
  assign ram_we    = !reset && (state_q == S_STORE_WR || state_q == S_RMW_WR);
  assign ram_wdata = (state_q == S_STORE_WR) ? wdata_q
                                              : store_merge(size_q, off_q, rd_word_q, wdata_q);

  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram_q[idx_q] <= ram_wdata;
    end
    if (state_q == S_IDLE) begin
      rd_word_q <= ram_q[bus.addr[ADDR_W+1:2]];
    end
  end

  assign bus.ready = (state_q == S_IDLE) && !reset;
  assign bus.done  = done_q;
  assign bus.err   = err_q;
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_data_mem_unit.sv
// ---------------------------------------------------------------------------
// tb_data_mem_unit
//   Directed stimulus with hand-computed expectations, plus a cycle-level
//   reference model kept as a byte-addressed memory and an absolute-cycle
//   schedule of when each accepted request completes.
// ---------------------------------------------------------------------------
module tb_data_mem_unit;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  data_mem_if bus();

  data_mem_unit #(.ADDR_W(8), .INIT_ZERO(1'b1)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit [7:0]    mmem [1024];        // 256 words as bytes, byte address wraps at 1 KiB
  int          cyc       = 0;
  int          free_at   = 0;
  int          done_at   = -1;
  bit          pend      = 1'b0;
  bit          pend_err, pend_load, pend_store;
  int          pend_addr, pend_nb;
  logic [31:0] pend_data, pend_rd;
  logic [31:0] cur_rdata = '0;
  bit          model_valid = 1'b0;

  function automatic int op_size(input logic [2:0] op);
    case (op[1:0])
      2'b00:   return 4;
      2'b01:   return 2;
      default: return 1;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input int a, input int sz);
    logic [31:0] v;
    longint      lv;
    v = '0;
    for (int b = 0; b < sz; b++) v = v | (32'(mmem[(a + b) & 1023]) << (8 * b));
    if (sz < 4) begin
      lv = longint'(v);
      if (lv >= (longint'(1) << (8 * sz - 1))) lv = lv - (longint'(1) << (8 * sz));
      v = lv[31:0];
    end
    return v;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      pend        = 1'b0;
      cur_rdata   = '0;
      free_at     = cyc + 1;
      model_valid = 1'b1;
    end else if (model_valid) begin
      if (pend && pend_load && cyc == done_at - 1) cur_rdata = pend_rd;
      if (pend && cyc == done_at) begin
        if (pend_store)
          for (int b = 0; b < pend_nb; b++) mmem[(pend_addr + b) & 1023] = pend_data[8*b +: 8];
        pend = 1'b0;
      end
      if (bus.req && cyc >= free_at) begin
        int  sz, lat;
        bit  bad;
        sz         = op_size(bus.op);
        bad        = (bus.op[1:0] == 2'b11) || ((int'(bus.addr[1:0]) % sz) != 0);
        pend_err   = bad;
        pend_load  = !bad && !bus.op[2];
        pend_store = !bad && bus.op[2];
        pend_addr  = int'(bus.addr[9:0]);
        pend_nb    = sz;
        pend_data  = bus.wdata;
        pend_rd    = model_load(pend_addr, sz);
        lat        = (bad || (bus.op[2] && sz == 4)) ? 1 : 2;
        done_at    = cyc + lat;
        free_at    = cyc + lat + 1;
        pend       = 1'b1;
      end
    end
    cyc++;
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (model_valid) begin
      bit exp_done;
      exp_done = pend && (cyc == done_at);
      chk("ready", {31'b0, bus.ready}, {31'b0, (!reset && cyc >= free_at)});
      chk("done",  {31'b0, bus.done},  {31'b0, exp_done});
      chk("err",   {31'b0, bus.err},   {31'b0, (exp_done && pend_err)});
      chk("rdata", bus.rdata, cur_rdata);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, input int exp_lat, input bit exp_err,
                       input logic [31:0] exp_rd);
    int n;
    bit got;
    @(posedge clk); #1;
    bus.req = 1'b1; bus.op = op; bus.addr = addr; bus.wdata = wdata;
    @(posedge clk); #1;
    // Scramble the inputs after acceptance; the unit must have latched them.
    bus.req = 1'b0; bus.op = 3'b111; bus.addr = 32'hFFFF_FFFF; bus.wdata = 32'hFFFF_FFFF;
    n = 0; got = 1'b0;
    while (!got && n < 8) begin
      @(negedge clk);
      n++;
      if (bus.done) got = 1'b1;
    end
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL %s_timeout: got no done within 8 cycles, required done", name);
    end else begin
      chk({name, "_lat"},   n, exp_lat);
      chk({name, "_err"},   {31'b0, bus.err}, {31'b0, exp_err});
      chk({name, "_rdata"}, bus.rdata, exp_rd);
    end
    $display("txn %-10s op=%03b addr=0x%08h wdata=0x%08h lat=%0d err=%0b rdata=0x%08h",
             name, op, addr, wdata, n, bus.err, bus.rdata);
  endtask

  initial begin
    bus.req = 1'b0; bus.op = 3'b000; bus.addr = '0; bus.wdata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'b0, bus.ready}, 32'd1);
    chk("rst_done",  {31'b0, bus.done},  32'd0);
    chk("rst_rdata", bus.rdata, 32'h0);

    do_op("sw10",    3'b100, 32'h10, 32'hDEADBEEF, 1, 1'b0, 32'h0000_0000);
    do_op("lw10",    3'b000, 32'h10, 32'h0,        2, 1'b0, 32'hDEADBEEF);
    do_op("lb13",    3'b010, 32'h13, 32'h0,        2, 1'b0, 32'hFFFFFFDE);
    do_op("lb10",    3'b010, 32'h10, 32'h0,        2, 1'b0, 32'hFFFFFFEF);
    do_op("lh12",    3'b001, 32'h12, 32'h0,        2, 1'b0, 32'hFFFFDEAD);
    do_op("lh10",    3'b001, 32'h10, 32'h0,        2, 1'b0, 32'hFFFFBEEF);
    do_op("sw20",    3'b100, 32'h20, 32'h00007F00, 1, 1'b0, 32'hFFFFBEEF);
    do_op("lb21",    3'b010, 32'h21, 32'h0,        2, 1'b0, 32'h0000007F);
    do_op("sb11",    3'b110, 32'h11, 32'h12345655, 2, 1'b0, 32'h0000007F);
    do_op("lw10b",   3'b000, 32'h10, 32'h0,        2, 1'b0, 32'hDEAD55EF);
    do_op("sh12",    3'b101, 32'h12, 32'h0000CAFE, 2, 1'b0, 32'hDEAD55EF);
    do_op("lw10c",   3'b000, 32'h10, 32'h0,        2, 1'b0, 32'hCAFE55EF);
    do_op("lw11",    3'b000, 32'h11, 32'h0,        1, 1'b1, 32'hCAFE55EF);
    do_op("sh13",    3'b101, 32'h13, 32'h0000BBBB, 1, 1'b1, 32'hCAFE55EF);
    do_op("op011",   3'b011, 32'h10, 32'h11111111, 1, 1'b1, 32'hCAFE55EF);
    do_op("op111",   3'b111, 32'h10, 32'h22222222, 1, 1'b1, 32'hCAFE55EF);
    do_op("sw_mis",  3'b100, 32'h12, 32'h33333333, 1, 1'b1, 32'hCAFE55EF);
    do_op("lw10d",   3'b000, 32'h10, 32'h0,        2, 1'b0, 32'hCAFE55EF);

    // Reset during the write cycle of an SB must cancel the write.
    @(posedge clk); #1;
    bus.req = 1'b1; bus.op = 3'b110; bus.addr = 32'h10; bus.wdata = 32'h000000AA;
    @(posedge clk); #1;
    bus.req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_rmw_done", {31'b0, bus.done}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_done",  {31'b0, bus.done}, 32'd0);
    chk("post_rst_err",   {31'b0, bus.err},  32'd0);
    chk("post_rst_rdata", bus.rdata, 32'h0);
    $display("txn %-10s reset during RMW write cycle", "sb_abort");
    do_op("lw10e",   3'b000, 32'h10, 32'h0,        2, 1'b0, 32'hCAFE55EF);

    // req held high; alternating SW via alias 0x440 and LW via 0x40.
    @(posedge clk); #1;
    bus.req = 1'b1;
    for (int j = 0; j < 6; j++) begin
      int k;
      bus.op    = (j % 2 == 0) ? 3'b100 : 3'b000;
      bus.addr  = (j % 2 == 0) ? 32'h440 : 32'h40;
      bus.wdata = 32'h1000_0000 + j;
      k = 0;
      while (!bus.ready && k < 8) begin
        @(posedge clk); #1;
        k++;
      end
      if (k == 8) begin
        n_checks++; n_fail++;
        $display("FAIL alias_ready_%0d: got ready=0 for 8 cycles, required ready=1", j);
      end
      @(posedge clk); #1;
      $display("txn alias_%0d   op=%03b addr=0x%08h wdata=0x%08h", j, bus.op, bus.addr, bus.wdata);
    end
    bus.req = 1'b0;
    repeat (3) @(negedge clk);
    chk("alias_rdata", bus.rdata, 32'h1000_0004);
    do_op("lw40",    3'b000, 32'h40, 32'h0,        2, 1'b0, 32'h10000004);
    do_op("lw10f",   3'b000, 32'h10, 32'h0,        2, 1'b0, 32'hCAFE55EF);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of test, required completion");
    $fatal(1, "timeout");
  end

endmodule
